// File: rtl/path_delay_pkg.sv
// Shared definitions for the path delay sampler: FSM states and default sizing.
package path_delay_pkg;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_DLY_W      = 8;
  localparam int DEF_SETTLE_CYC = 16;
  localparam bit DEF_INVERT     = 1'b0;

  // Settle counter width covers the full legal SETTLE_CYC range.
  localparam int SETTLE_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRESET,
    LAUNCH_WAIT,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/path_delay_sampler_if.sv
// Control/status bundle of the path delay sampler.
// master = requester that starts runs, slave = the sampler itself.
interface path_delay_sampler_if
  import path_delay_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DLY_W = DEF_DLY_W
);

  logic             start;
  logic [DLY_W-1:0] capture_dly;
  logic [CNT_W-1:0] num_trials;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] fail_count;
  logic             last_sample;

  modport master (
    output start, capture_dly, num_trials,
    input  busy, done, fail_count, last_sample
  );

  modport slave (
    input  start, capture_dly, num_trials,
    output busy, done, fail_count, last_sample
  );

endinterface

// File: rtl/path_delay_capture.sv
// Launch flop and capture flop of the measured path, kept in their own
// module so placement constraints can pin them next to the chain.
module path_delay_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic launchEn,
  input  logic launchD,
  input  logic capEn,
  input  logic path_out,
  output logic path_in,
  output logic sample
);

  // Launch flop: its Q drives the chain with nothing in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        path_in <= 1'b0;
    else if (launchEn) path_in <= launchD;
  end

  // Capture flop: samples the raw chain output, deliberately unsynchronized,
  // since a late transition is exactly what is being measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sample <= 1'b0;
    else if (capEn) sample <= path_out;
  end

endmodule

// File: rtl/path_delay_sampler.sv
// Path delay sampler: repeatedly launches alternating edges into a delay
// chain and checks whether each edge arrives by a programmable capture edge.
module path_delay_sampler
  import path_delay_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DLY_W      = DEF_DLY_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter bit INVERT     = DEF_INVERT
) (
  input  logic                clk,
  input  logic                rst_n,
  path_delay_sampler_if.slave ctl,
  output logic                path_in,
  input  logic                path_out
);

  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  state_t              state, stateNxt;
  logic [DLY_W-1:0]    dlyLat, dlyCnt;
  logic [CNT_W-1:0]    trialsLat, trialCnt, failCnt, trialNext;
  logic [SETTLE_W-1:0] settleCnt;
  logic                launchVal;
  logic                launchEn, launchD, capEn;
  logic                sample, mismatch;

  assign trialNext = trialCnt + 1'b1;
  // Expected value at the capture flop folds in the chain's inversion parity.
  assign mismatch  = sample != (launchVal ^ INVERT);

  path_delay_capture uCap (
    .clk      (clk),
    .rst_n    (rst_n),
    .launchEn (launchEn),
    .launchD  (launchD),
    .capEn    (capEn),
    .path_out (path_out),
    .path_in  (path_in),
    .sample   (sample)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  // Next state plus launch/capture enables.
  always_comb begin
    stateNxt = state;
    launchEn = 1'b0;
    launchD  = launchVal;
    capEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctl.start) begin
          if (ctl.num_trials == '0) begin
            stateNxt = DONE;
          end else begin
            // First trial is a rising launch, so preset the chain low.
            stateNxt = PRESET;
            launchEn = 1'b1;
            launchD  = 1'b0;
          end
        end
      end
      PRESET: begin
        if (settleCnt == SETTLE_LAST) begin
          stateNxt = LAUNCH_WAIT;
          launchEn = 1'b1;
          launchD  = launchVal;
        end
      end
      LAUNCH_WAIT: begin
        if (dlyCnt == '0) begin
          capEn    = 1'b1;
          stateNxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (trialNext == trialsLat) begin
          stateNxt = DONE;
        end else begin
          // Next preset level is ~(toggled launchVal), i.e. the level just launched.
          stateNxt = PRESET;
          launchEn = 1'b1;
          launchD  = launchVal;
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Run settings, counters and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dlyLat    <= '0;
      dlyCnt    <= '0;
      trialsLat <= '0;
      trialCnt  <= '0;
      failCnt   <= '0;
      settleCnt <= '0;
      launchVal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl.start) begin
            dlyLat    <= ctl.capture_dly;
            trialsLat <= ctl.num_trials;
            trialCnt  <= '0;
            failCnt   <= '0;
            settleCnt <= '0;
            launchVal <= 1'b1;
          end
        end
        PRESET: begin
          if (settleCnt == SETTLE_LAST) begin
            settleCnt <= '0;
            dlyCnt    <= dlyLat;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end
        LAUNCH_WAIT: begin
          if (dlyCnt != '0) dlyCnt <= dlyCnt - 1'b1;
        end
        CAPTURE: begin
          if (mismatch && (failCnt != CNT_MAX)) failCnt <= failCnt + 1'b1;
          trialCnt  <= trialNext;
          launchVal <= ~launchVal;
        end
        default: ;
      endcase
    end
  end

  assign ctl.busy        = (state == PRESET) || (state == LAUNCH_WAIT) || (state == CAPTURE);
  assign ctl.done        = (state == DONE);
  assign ctl.fail_count  = failCnt;
  assign ctl.last_sample = sample;

endmodule

// File: doc/path_delay_sampler.md
PATH_DELAY_SAMPLER -- requirements
Module: path_delay_sampler

Interface
REQ-001 Parameter CNT_W, default 16, width of trial count and failure count.
REQ-002 Parameter DLY_W, default 8, width of capture delay setting.
REQ-003 Parameter SETTLE_CYC, default 16, preset settle cycles before each launch; legal range 1 to 2^16-1.
REQ-004 Parameter INVERT, default 0, 1 when the attached chain has odd inversion parity.
REQ-005 clk  input  1  single clock; all flops rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin a measurement run.
REQ-008 capture_dly  input  DLY_W  clock edges between launch edge and capture edge, minus one.
REQ-009 num_trials  input  CNT_W  launches per run.
REQ-010 path_in  output  1  registered launch signal driving the chain input.
REQ-011 path_out  input  1  chain output, asynchronous to the launch timing.
REQ-012 busy  output  1  high from the start-accept edge until done.
REQ-013 done  output  1  one-cycle pulse at run end.
REQ-014 fail_count  output  CNT_W  late-arrival count for the current or last run.
REQ-015 last_sample  output  1  most recent captured path_out value.

Function
REQ-016 FSM states: IDLE, PRESET, LAUNCH_WAIT, CAPTURE, DONE.
REQ-017 In IDLE, start=1 latches capture_dly and num_trials, clears fail_count and the trial counter, and sets launch_val=1.
- num_trials=0: go to DONE; otherwise go to PRESET.
REQ-018 start while busy shall be ignored; latched settings shall not change mid-run.
REQ-019 PRESET: drive path_in=~launch_val for exactly SETTLE_CYC cycles, then drive path_in=launch_val on the exit edge (the launch edge) and enter LAUNCH_WAIT.
REQ-020 LAUNCH_WAIT: count down the latched capture_dly; path_out is registered on the (capture_dly+1)-th edge after the launch edge.
- capture_dly=0: capture on the first edge after launch.
REQ-021 CAPTURE: mismatch when sample != (launch_val XOR INVERT); on mismatch increment fail_count, saturating at 2^CNT_W-1.
- last_sample is updated every trial.
REQ-022 After CAPTURE, increment the trial counter and toggle launch_val.
- Counter equals latched num_trials: go to DONE; otherwise return to PRESET.
- Trials alternate rising and falling launches.
REQ-023 DONE: done=1 for one cycle, busy=0 on the same cycle, then IDLE; fail_count and last_sample hold until the next accepted start.
REQ-024 path_in shall be a single flop output with no combinational logic after it; the capture flop shall sample path_out directly, with no synchronizer.

Reset
REQ-025 rst_n low shall asynchronously force: FSM=IDLE, path_in=0, busy=0, done=0, fail_count=0, last_sample=0, all counters=0.
REQ-026 Reset asserted mid-run shall abort the run with no done pulse; operation restarts only on a new start after deassertion.

Structure
REQ-027 FSM state enum and the default parameter values shall live in shared package path_delay_pkg.
REQ-028 One sub-module, path_delay_capture: the launch flop plus the capture flop with its enable, kept separate so placement constraints can target it.

Verification
Bench uses a behavioural chain model, path_out = path_in delayed D clock cycles, unless stated otherwise.
REQ-029 D=2, capture_dly=5, num_trials=10 -> done after the run, fail_count=0, last_sample=0.
REQ-030 D=4, capture_dly=1, num_trials=8 -> fail_count=8, done pulse exactly one cycle.
REQ-031 num_trials=0, start -> done one cycle after the start-accept edge, fail_count=0, path_in never toggles.
REQ-032 INVERT=1, inverting model with D=1, capture_dly=3, num_trials=4 -> fail_count=0.
REQ-033 Pulse start repeatedly mid-run, then assert rst_n low for 2 cycles mid-run -> repeated starts ignored, all outputs reset immediately, no done pulse; the next run completes normally.
REQ-034 CNT_W=4, D=4, capture_dly=0, num_trials=15 -> fail_count saturates at 15, no wrap.
